// File: rtl/s32x_irl_encoder.sv
// s32x_irl_encoder: external interrupt source for one SH7604 core (32X side).
// Latches VRES/V/H/CMD/PWM events into PEND, masks them, drives the highest
// pending level onto the active-low IRL pins with a minimum hold time, and
// answers external vector fetches on the vector bus.
// Optional feature: define IRL_AUTOCLR_EN to clear the acknowledged source's
// PEND bit when a vector fetch completes.
module s32x_irl_encoder #(
    parameter int unsigned HOLD_CYCLES = 6,
    parameter int unsigned VEC_WAIT    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        VRES_EV,
    input  logic        VINT_EV,
    input  logic        HBLK_EV,
    input  logic        CMD_EV,
    input  logic        PWM_EV,
    input  logic        REG_SEL,
    input  logic        REG_WE,
    input  logic [1:0]  REG_A,
    input  logic [15:0] REG_DI,
    output logic [15:0] REG_DO,
    output logic [3:0]  IRL_N,
    input  logic [3:0]  VBUS_A,
    input  logic        VBUS_REQ,
    output logic [7:0]  VBUS_DO,
    output logic        VBUS_WAIT
);

    localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] WAIT_RELOAD = 3'(VEC_WAIT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} vec_state_e;

    logic [3:0]  mask_q;
    logic [7:0]  hcnt_q;
    logic [7:0]  lc_q;
    logic [7:0]  vbase_q;
    logic [4:0]  pend_q;
    logic [4:0]  pend_d;
    logic [15:0] reg_do_q;
    logic [15:0] rd_data;
    logic [3:0]  out_lvl_q;
    logic [3:0]  hc_q;
    logic [3:0]  cand;
    logic [4:0]  masked;
    vec_state_e  state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  vbus_do_q;

    logic        reg_wr;
    logic        reg_rd;
    logic        h_set;
    logic        enter_done;
    logic [4:0]  ev_set;
    logic [4:0]  clr_bits;
    logic [4:0]  ack_bits;
    logic        unused_bits;

    assign reg_wr = REG_SEL & REG_WE;
    assign reg_rd = REG_SEL & ~REG_WE;

    // H fires only on an underflowing HBLK; a coincident VINT reload suppresses it.
    assign h_set    = HBLK_EV && !VINT_EV && (lc_q == 8'd0);
    assign ev_set   = {VRES_EV, VINT_EV, h_set, CMD_EV, PWM_EV};
    assign clr_bits = (reg_wr && (REG_A == 2'd2)) ? REG_DI[4:0] : 5'd0;
    // Events are OR-ed in after clearing so a same-cycle event always wins.
    assign pend_d   = (pend_q & ~(clr_bits | ack_bits)) | ev_set;

    // cnt_q holds the WAIT cycles still owed including the current one; DONE is
    // entered on the edge where it would reach 0 (straight from IDLE if VEC_WAIT==1).
    assign enter_done = VBUS_REQ &&
        (((state_q == StIdle) && (VEC_WAIT == 1)) || ((state_q == StBusy) && (cnt_q == 3'd1)));

    assign unused_bits = ^{REG_DI[15:8], VBUS_A[0]};

    // Select the PEND bit matching the acknowledged level at fetch completion.
    always_comb begin
        ack_bits = 5'd0;
`ifdef IRL_AUTOCLR_EN
        if (enter_done) begin
            case (VBUS_A)
                4'd14:   ack_bits = 5'b10000;
                4'd12:   ack_bits = 5'b01000;
                4'd10:   ack_bits = 5'b00100;
                4'd8:    ack_bits = 5'b00010;
                4'd6:    ack_bits = 5'b00001;
                default: ack_bits = 5'd0;
            endcase
        end
`endif
    end

    // Priority-encode the highest enabled pending source; VRES is never masked.
    always_comb begin
        masked = pend_q & {1'b1, mask_q};
        if (masked[4])      cand = 4'd14;
        else if (masked[3]) cand = 4'd12;
        else if (masked[2]) cand = 4'd10;
        else if (masked[1]) cand = 4'd8;
        else if (masked[0]) cand = 4'd6;
        else                cand = 4'd0;
    end

    // Register read mux; unused bits read as zero.
    always_comb begin
        rd_data = 16'd0;
        case (REG_A)
            2'd0:    rd_data = {12'd0, mask_q};
            2'd1:    rd_data = {8'd0, hcnt_q};
            2'd2:    rd_data = {11'd0, pend_q};
            default: rd_data = {8'd0, vbase_q};
        endcase
    end

    // Register file, pending latches and the H-line counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mask_q   <= 4'd0;
            hcnt_q   <= 8'd0;
            lc_q     <= 8'd0;
            vbase_q  <= 8'h40;
            pend_q   <= 5'd0;
            reg_do_q <= 16'd0;
        end else begin
            pend_q <= pend_d;
            if (reg_rd) reg_do_q <= rd_data;
            if (reg_wr && (REG_A == 2'd0)) mask_q  <= REG_DI[3:0];
            if (reg_wr && (REG_A == 2'd1)) hcnt_q  <= REG_DI[7:0];
            if (reg_wr && (REG_A == 2'd3)) vbase_q <= REG_DI[7:0];
            if (reg_wr && (REG_A == 2'd1)) lc_q <= REG_DI[7:0];
            else if (VINT_EV)              lc_q <= hcnt_q;
            else if (HBLK_EV)              lc_q <= (lc_q == 8'd0) ? hcnt_q : lc_q - 8'd1;
        end
    end

    // IRL level update paced by CE; each new level is held HOLD_CYCLES ticks.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_lvl_q <= 4'd0;
            hc_q      <= 4'd0;
        end else if (CE) begin
            if (hc_q != 4'd0) begin
                hc_q <= hc_q - 4'd1;
            end else if (cand != out_lvl_q) begin
                out_lvl_q <= cand;
                hc_q      <= HOLD_RELOAD;
            end
        end
    end

    // Vector fetch FSM; data is captured on the edge that enters DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            vbus_do_q <= 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (VBUS_REQ) begin
                        state_q <= enter_done ? StDone : StBusy;
                        cnt_q   <= WAIT_RELOAD;
                    end
                end
                StBusy: begin
                    if (!VBUS_REQ)       state_q <= StIdle;
                    else if (enter_done) state_q <= StDone;
                    else                 cnt_q   <= cnt_q - 3'd1;
                end
                StDone: begin
                    if (!VBUS_REQ) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (enter_done) vbus_do_q <= vbase_q + {5'd0, VBUS_A[3:1]};
        end
    end

    assign IRL_N     = ~out_lvl_q;
    assign REG_DO    = reg_do_q;
    assign VBUS_DO   = vbus_do_q;
    assign VBUS_WAIT = VBUS_REQ && (state_q != StDone);

endmodule

// File: tb/tb_s32x_irl_encoder.sv
// Bench for s32x_irl_encoder: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_s32x_irl_encoder;

    localparam int unsigned HOLD = 6;
    localparam int unsigned VW   = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE;
    logic        VRES_EV, VINT_EV, HBLK_EV, CMD_EV, PWM_EV;
    logic        REG_SEL, REG_WE;
    logic [1:0]  REG_A;
    logic [15:0] REG_DI;
    logic [15:0] REG_DO;
    logic [3:0]  IRL_N;
    logic [3:0]  VBUS_A;
    logic        VBUS_REQ;
    logic [7:0]  VBUS_DO;
    logic        VBUS_WAIT;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: source levels indexed by PEND bit position.
    int lvl[5] = '{6, 8, 10, 12, 14};
    bit m_pend[5];
    int m_mask, m_hcnt, m_lc, m_vbase, m_out, m_hc, m_reg_do, m_vdo, m_req_run;

    s32x_irl_encoder #(.HOLD_CYCLES(HOLD), .VEC_WAIT(VW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .VRES_EV   (VRES_EV),
        .VINT_EV   (VINT_EV),
        .HBLK_EV   (HBLK_EV),
        .CMD_EV    (CMD_EV),
        .PWM_EV    (PWM_EV),
        .REG_SEL   (REG_SEL),
        .REG_WE    (REG_WE),
        .REG_A     (REG_A),
        .REG_DI    (REG_DI),
        .REG_DO    (REG_DO),
        .IRL_N     (IRL_N),
        .VBUS_A    (VBUS_A),
        .VBUS_REQ  (VBUS_REQ),
        .VBUS_DO   (VBUS_DO),
        .VBUS_WAIT (VBUS_WAIT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int cand_level();
        int best = 0;
        for (int i = 0; i < 5; i++)
            if (m_pend[i] && (i == 4 || ((m_mask >> i) & 1) == 1)) best = lvl[i];
        return best;
    endfunction

    function automatic int read_value(input logic [1:0] a);
        int p = 0;
        for (int i = 0; i < 5; i++) if (m_pend[i]) p += (1 << i);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_hcnt;
            2'd2:    return p;
            default: return m_vbase;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_pend[i] = 1'b0;
        m_mask = 0; m_hcnt = 0; m_lc = 0; m_vbase = 'h40;
        m_out = 0; m_hc = 0; m_reg_do = 0; m_vdo = 0; m_req_run = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        int cand;
        bit wr, rd, h_fire;
        bit ev[5];
        bit clr[5];
        cand   = cand_level();
        wr     = REG_SEL && REG_WE;
        rd     = REG_SEL && !REG_WE;
        h_fire = HBLK_EV && !VINT_EV && (m_lc == 0);
        ev     = '{PWM_EV, CMD_EV, h_fire, VINT_EV, VRES_EV};
        if (rd) m_reg_do = read_value(REG_A);
        for (int i = 0; i < 5; i++) clr[i] = wr && (REG_A == 2'd2) && REG_DI[i];
        if (VBUS_REQ) begin
            if (m_req_run == int'(VW) - 1) begin
                m_vdo = (m_vbase + int'(VBUS_A) / 2) % 256;
`ifdef IRL_AUTOCLR_EN
                for (int i = 0; i < 5; i++) if (lvl[i] == int'(VBUS_A)) clr[i] = 1'b1;
`endif
            end
            if (m_req_run < 1000) m_req_run++;
        end else begin
            m_req_run = 0;
        end
        if (CE) begin
            if (m_hc > 0) m_hc--;
            else if (cand != m_out) begin
                m_out = cand;
                m_hc  = HOLD - 1;
            end
        end
        if (wr && REG_A == 2'd1) m_lc = int'(REG_DI[7:0]);
        else if (VINT_EV)        m_lc = m_hcnt;
        else if (HBLK_EV)        m_lc = (m_lc == 0) ? m_hcnt : m_lc - 1;
        for (int i = 0; i < 5; i++) m_pend[i] = ev[i] || (m_pend[i] && !clr[i]);
        if (wr) begin
            case (REG_A)
                2'd0:    m_mask  = int'(REG_DI[3:0]);
                2'd1:    m_hcnt  = int'(REG_DI[7:0]);
                2'd3:    m_vbase = int'(REG_DI[7:0]);
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("irl_n", IRL_N, 32'(15 - m_out));
        chk("reg_do", REG_DO, 32'(m_reg_do));
        chk("vbus_do", VBUS_DO, 32'(m_vdo));
        chk("vbus_wait", VBUS_WAIT, 32'(VBUS_REQ && (m_req_run < int'(VW))));
    endtask

    task automatic step();
        @(posedge CLK);
        if (!RST) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        VRES_EV = 0; VINT_EV = 0; HBLK_EV = 0; CMD_EV = 0; PWM_EV = 0;
        REG_SEL = 0; REG_WE = 0; REG_A = 2'd0; REG_DI = 16'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        VBUS_REQ = 0;
        RST = 1;
        model_reset();
        #1;
        check_outputs();
        @(posedge CLK);
        #1;
        RST = 0;
        check_outputs();
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        REG_SEL = 1; REG_WE = 1; REG_A = a; REG_DI = d;
        step();
        REG_SEL = 0; REG_WE = 0;
    endtask

    task automatic reg_read(input logic [1:0] a);
        REG_SEL = 1; REG_WE = 0; REG_A = a;
        step();
        REG_SEL = 0;
    endtask

    task automatic settle_zero();
        int n = 0;
        while (IRL_N !== 4'hF && n < 60) begin step(); n++; end
        chk("settle_irl", IRL_N, 4'hF);
        for (int i = 0; i < int'(HOLD); i++) step();
    endtask

    initial begin
        int n;
        RST = 0; CE = 1; VBUS_REQ = 0; VBUS_A = 4'd0;
        idle_inputs();
        model_reset();
        #2;
        do_reset();
        chk("rst_irl", IRL_N, 4'hF);
        chk("rst_vbus_do", VBUS_DO, 8'h00);

        // CMD with all sources enabled reaches the pins as level 8.
        reg_write(2'd0, 16'h000F);
        CMD_EV = 1; step(); CMD_EV = 0;
        n = 0;
        while (IRL_N !== 4'h7 && n < 20) begin step(); n++; end
        chk("cmd_irl", IRL_N, 4'h7);
        chk("cmd_latency", 32'(n <= int'(HOLD) + 1), 1);

        // PWM level is held the full hold time before V takes over.
        reg_write(2'd2, 16'h001F);
        settle_zero();
        PWM_EV = 1; step(); PWM_EV = 0;
        n = 0;
        while (IRL_N !== 4'h9 && n < 20) begin step(); n++; end
        chk("pwm_irl", IRL_N, 4'h9);
        VINT_EV = 1; step(); VINT_EV = 0;
        n = 1;
        while (IRL_N === 4'h9 && n < 40) begin step(); n++; end
        chk("v_irl", IRL_N, 4'h3);
        chk("pwm_hold", 32'(n >= int'(HOLD)), 1);

        // H line counter: HCNT=2 sets H on the third HBLK.
        reg_write(2'd2, 16'h001F);
        reg_write(2'd1, 16'd2);
        for (int i = 0; i < 2; i++) begin HBLK_EV = 1; step(); HBLK_EV = 0; end
        reg_read(2'd2);
        chk("h_not_yet", REG_DO[2], 1'b0);
        HBLK_EV = 1; step(); HBLK_EV = 0;
        reg_read(2'd2);
        chk("h_set", REG_DO[2], 1'b1);

        // Vector fetch at level 12 with the reset VBASE.
        VBUS_A = 4'd12; VBUS_REQ = 1;
        #1;
        chk("wait_first", VBUS_WAIT, 1'b1);
        n = 0;
        while (VBUS_WAIT === 1'b1 && n < 20) begin step(); n++; end
        chk("wait_len", n, VW);
        chk("vec_data", VBUS_DO, 8'h46);
        VBUS_REQ = 0; step();

        // CLEAR of V coinciding with VINT leaves V pending.
        REG_SEL = 1; REG_WE = 1; REG_A = 2'd2; REG_DI = 16'h0008; VINT_EV = 1;
        step();
        idle_inputs();
        reg_read(2'd2);
        chk("clr_vs_set", REG_DO[3], 1'b1);

`ifdef IRL_AUTOCLR_EN
        // Acknowledging VRES clears it; the pins return to idle after the hold.
        reg_write(2'd0, 16'h0000);
        reg_write(2'd2, 16'h001F);
        settle_zero();
        VRES_EV = 1; step(); VRES_EV = 0;
        n = 0;
        while (IRL_N !== 4'h1 && n < 20) begin step(); n++; end
        chk("vres_irl", IRL_N, 4'h1);
        VBUS_A = 4'd14; VBUS_REQ = 1;
        n = 0;
        while (VBUS_WAIT === 1'b1 && n < 20) begin step(); n++; end
        VBUS_REQ = 0; step();
        reg_read(2'd2);
        chk("autoclr", REG_DO[4], 1'b0);
        n = 0;
        while (IRL_N !== 4'hF && n < 20) begin step(); n++; end
        chk("autoclr_irl", IRL_N, 4'hF);
`endif

        // Random traffic, with one reset mid-run.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            CE      = 1'($urandom_range(0, 1));
            VRES_EV = ($urandom_range(0, 63) == 0);
            VINT_EV = ($urandom_range(0, 15) == 0);
            HBLK_EV = ($urandom_range(0, 3) == 0);
            CMD_EV  = ($urandom_range(0, 15) == 0);
            PWM_EV  = ($urandom_range(0, 15) == 0);
            REG_SEL = ($urandom_range(0, 7) == 0);
            REG_WE  = 1'($urandom_range(0, 1));
            REG_A   = 2'($urandom_range(0, 3));
            REG_DI  = 16'($urandom);
            if (REG_A == 2'd1) REG_DI = 16'($urandom_range(0, 3));
            if (VBUS_REQ) begin
                if ($urandom_range(0, 4) == 0) VBUS_REQ = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                VBUS_REQ = 1;
                if ($urandom_range(0, 1) == 1) VBUS_A = 4'(6 + 2 * $urandom_range(0, 4));
                else                           VBUS_A = 4'($urandom);
            end
            step();
        end

        idle_inputs();
        VBUS_REQ = 0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
